// File: rtl/dff_delay_line.sv
// Purpose : DEPTH-stage, WIDTH-bit enable-gated delay line with per-stage valid, flush and occupancy count.
// Latency : DEPTH enabled edges from capture to q; each en=0 cycle adds one cycle.
// Backpressure: en=0 stalls every stage in place; no ready output, the upstream must honour en itself.
module dff_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         flush,
   input  logic [WIDTH-1:0]             d,
   input  logic                         d_valid,
   output logic [WIDTH-1:0]             q,
   output logic                         q_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);

   // Stage storage; stage 0 is the input end, stage DEPTH-1 drives q.
   logic [WIDTH-1:0] s [DEPTH];
   logic [DEPTH-1:0] v;
   logic [CW-1:0]    count_nxt;

   // Occupancy after an advance: one word may enter and one may leave on the same edge.
   always_comb begin
      count_nxt = count + CW'(d_valid) - CW'(v[DEPTH-1]);
   end

   // Stage shift with reset > flush > enable > hold priority; bubbles carry zero data.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            s[i] <= '0;
         end
         v     <= '0;
         count <= '0;
      end else if (en) begin
         s[0] <= d_valid ? d : '0;
         v[0] <= d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            s[i] <= s[i-1];
            v[i] <= v[i-1];
         end
         count <= count_nxt;
      end
   end

   // Outputs come straight from the last stage registers.
   always_comb begin
      q       = s[DEPTH-1];
      q_valid = v[DEPTH-1];
   end

endmodule

// File: tb/tb_dff_delay_line.sv
module tb_dff_delay_line;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [7:0] q;
      logic       qv;
      logic [2:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, en, flush, d_valid;
   logic [7:0] d;
   logic [7:0] q;
   logic       q_valid;
   logic [2:0] count;

   int vectors = 0;
   int miscompares = 0;

   exp_t  exp_q [$];
   string nm_q  [$];

   // reference model: enabled-edge counter plus list of captured words tagged with capture index
   int       en_cnt = 0;
   int       cap_idx [$];
   logic [7:0] cap_dat [$];

   always #5 clk = ~clk;

   dff_delay_line #(.WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .flush  (flush),
      .d      (d),
      .d_valid(d_valid),
      .q      (q),
      .q_valid(q_valid),
      .count  (count)
   );

   task automatic model_edge(input logic r, input logic e, input logic f,
                             input logic dv, input logic [7:0] dd);
      if (!r || f) begin
         en_cnt = 0;
         cap_idx.delete();
         cap_dat.delete();
      end else if (e) begin
         en_cnt++;
         if (dv) begin
            cap_idx.push_back(en_cnt);
            cap_dat.push_back(dd);
         end
         while (cap_idx.size() > 0 && cap_idx[0] <= en_cnt - DEPTH) begin
            void'(cap_idx.pop_front());
            void'(cap_dat.pop_front());
         end
      end
   endtask

   function automatic exp_t model_exp();
      exp_t x;
      x.q   = 8'h00;
      x.qv  = 1'b0;
      x.cnt = 3'(cap_idx.size());
      if (cap_idx.size() > 0 && cap_idx[0] == en_cnt - DEPTH + 1) begin
         x.q  = cap_dat[0];
         x.qv = 1'b1;
      end
      return x;
   endfunction

   task automatic drive_edge(input logic r, input logic e, input logic f,
                             input logic dv, input logic [7:0] dd);
      @(negedge clk);
      reset = r; en = e; flush = f; d_valid = dv; d = dd;
      @(posedge clk);
      model_edge(r, e, f, dv, dd);
   endtask

   // directed step: expected values are hand-computed in the tables below
   task automatic dstep(input logic r, input logic e, input logic f, input logic dv,
                        input logic [7:0] dd, input logic [7:0] eq, input logic eqv,
                        input logic [2:0] ec, input string nm);
      exp_t x;
      drive_edge(r, e, f, dv, dd);
      x.q = eq; x.qv = eqv; x.cnt = ec;
      exp_q.push_back(x);
      nm_q.push_back(nm);
   endtask

   task automatic sstep(input logic r, input logic e, input logic f,
                        input logic dv, input logic [7:0] dd);
      drive_edge(r, e, f, dv, dd);
      exp_q.push_back(model_exp());
      nm_q.push_back("soak");
   endtask

   // monitor: the DUT presents q/q_valid/count every cycle; compare against the oldest expectation
   initial begin
      exp_t  x;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x  = exp_q.pop_front();
            nm = nm_q.pop_front();
            vectors++;
            if (q !== x.q || q_valid !== x.qv || count !== x.cnt) begin
               miscompares++;
               $display("FAIL %s t=%0t: got q=%h q_valid=%b count=%0d, expected q=%h q_valid=%b count=%0d",
                        nm, $time, q, q_valid, count, x.q, x.qv, x.cnt);
            end
         end
      end
   end

   initial begin
      reset = 1'b0; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = 8'h00;

      // reset held low with live inputs
      dstep(0, 1, 0, 1, 8'hFF, 8'h00, 0, 3'd0, "reset0");
      dstep(0, 1, 0, 1, 8'hFF, 8'h00, 0, 3'd0, "reset1");

      // streaming
      dstep(1, 1, 0, 1, 8'h11, 8'h00, 0, 3'd1, "stream1");
      dstep(1, 1, 0, 1, 8'h22, 8'h00, 0, 3'd2, "stream2");
      dstep(1, 1, 0, 1, 8'h33, 8'h00, 0, 3'd3, "stream3");
      dstep(1, 1, 0, 1, 8'h44, 8'h11, 1, 3'd4, "stream4");
      dstep(1, 1, 0, 1, 8'h55, 8'h22, 1, 3'd4, "stream5");
      dstep(1, 1, 0, 0, 8'h00, 8'h33, 1, 3'd3, "stream6");
      dstep(1, 1, 0, 0, 8'h00, 8'h44, 1, 3'd2, "stream7");
      dstep(1, 1, 0, 0, 8'h00, 8'h55, 1, 3'd1, "stream8");
      dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd0, "stream9");

      // stall: EE offered while en is low must never be taken
      dstep(1, 1, 0, 1, 8'hA1, 8'h00, 0, 3'd1, "stall_ld1");
      dstep(1, 1, 0, 1, 8'hA2, 8'h00, 0, 3'd2, "stall_ld2");
      dstep(1, 0, 0, 1, 8'hEE, 8'h00, 0, 3'd2, "stall_hold1");
      dstep(1, 0, 0, 1, 8'hEE, 8'h00, 0, 3'd2, "stall_hold2");
      dstep(1, 0, 0, 1, 8'hEE, 8'h00, 0, 3'd2, "stall_hold3");
      dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd2, "stall_run1");
      dstep(1, 1, 0, 0, 8'h00, 8'hA1, 1, 3'd2, "stall_out_a1");
      dstep(1, 1, 0, 0, 8'h00, 8'hA2, 1, 3'd1, "stall_out_a2");
      dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd0, "stall_empty");

      // bubbles: invalid word data must read as zero
      dstep(1, 1, 0, 1, 8'h01, 8'h00, 0, 3'd1, "bub1");
      dstep(1, 1, 0, 0, 8'h77, 8'h00, 0, 3'd1, "bub2");
      dstep(1, 1, 0, 1, 8'h03, 8'h00, 0, 3'd2, "bub3");
      dstep(1, 1, 0, 0, 8'h00, 8'h01, 1, 3'd2, "bub_out01");
      dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd1, "bub_out_hole");
      dstep(1, 1, 0, 0, 8'h00, 8'h03, 1, 3'd1, "bub_out03");
      dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd0, "bub_empty");

      // flush together with en and a valid word
      dstep(1, 1, 0, 1, 8'hB1, 8'h00, 0, 3'd1, "fl_ld1");
      dstep(1, 1, 0, 1, 8'hB2, 8'h00, 0, 3'd2, "fl_ld2");
      dstep(1, 1, 0, 1, 8'hB3, 8'h00, 0, 3'd3, "fl_ld3");
      dstep(1, 1, 1, 1, 8'h99, 8'h00, 0, 3'd0, "flush");
      for (int i = 0; i < DEPTH; i++)
         dstep(1, 1, 0, 0, 8'h00, 8'h00, 0, 3'd0, "fl_drain");

      // random soak with two reset pulses
      for (int c = 0; c < 2000; c++) begin
         logic r, e, f, dv;
         r  = !(c == 600 || c == 601 || c == 1400);
         e  = ($urandom_range(0, 99) < 75);
         f  = ($urandom_range(0, 99) < 4);
         dv = ($urandom_range(0, 99) < 60);
         sstep(r, e, f, dv, 8'($urandom_range(0, 255)));
      end

      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
